// File: rtl/mem_stage_hs.sv
// Memory-access pipeline stage between EXU and WBU: one slot, valid/ready on both sides,
// req/ack bus with byte-lane store alignment, load extension and exception reporting.
module mem_stage_hs #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_alu_data,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_rd_wr,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [31:0]       in_store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_reg_data,
  output logic [REG_AW-1:0] out_reg_addr,
  output logic              out_reg_wr,
  output logic [1:0]        out_exc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ExcNone    = 2'd0;
  localparam logic [1:0] ExcMisal   = 2'd1;
  localparam logic [1:0] ExcBus     = 2'd2;
  localparam logic [1:0] ExcTimeout = 2'd3;

  typedef enum logic [1:0] {StIdle, StAccess, StHold} state_e;

  state_e              state_q, state_d;
  logic [31:0]         reg_data_q, reg_data_d;
  logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_wr_q, rd_wr_d;
  logic [1:0]          exc_q, exc_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          off_q, off_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                flushed_q, flushed_d;

  logic        capture;
  logic        is_mem;
  logic        misaligned;
  logic        timed_out;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign in_ready  = (state_q == StIdle) | ((state_q == StHold) & out_ready);
  assign capture   = in_valid & in_ready & ~flush;
  assign is_mem    = in_mem_rd | in_mem_wr;
  assign out_valid = (state_q == StHold) & ~flush;

  assign out_reg_data = reg_data_q;
  assign out_reg_addr = rd_addr_q;
  assign out_reg_wr   = rd_wr_q;
  assign out_exc      = exc_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;

  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_mem_addr[0];
      2'd2:    misaligned = |in_mem_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Timeout fires on the last allowed request cycle, so mem_req is seen for TIMEOUT cycles.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    reg_data_d = reg_data_q;
    rd_addr_d  = rd_addr_q;
    rd_wr_d    = rd_wr_q;
    exc_d      = exc_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    size_d     = size_q;
    signed_d   = signed_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;

    unique case (state_q)
      StIdle, StHold: begin
        if (flush) begin
          state_d = StIdle;
        end else if (capture) begin
          reg_data_d = in_alu_data;
          rd_addr_d  = in_rd_addr;
          rd_wr_d    = in_rd_wr;
          exc_d      = ExcNone;
          size_d     = in_size;
          signed_d   = in_signed;
          off_d      = in_mem_addr[1:0];
          cnt_d      = '0;
          flushed_d  = 1'b0;
          if (!is_mem) begin
            state_d = StHold;
          end else if (misaligned) begin
            state_d = StHold;
            exc_d   = ExcMisal;
            rd_wr_d = 1'b0;
          end else begin
            state_d = StAccess;
            req_d   = 1'b1;
            we_d    = in_mem_wr;
            addr_d  = {in_mem_addr[ADDR_W-1:2], 2'b00};
            wstrb_d = 4'h0;
            wdata_d = in_store_data;
            if (in_mem_wr) begin
              case (in_size)
                2'd0: begin
                  wdata_d = {4{in_store_data[7:0]}};
                  wstrb_d = 4'b0001 << in_mem_addr[1:0];
                end
                2'd1: begin
                  wdata_d = {2{in_store_data[15:0]}};
                  wstrb_d = 4'b0011 << in_mem_addr[1:0];
                end
                default: wstrb_d = 4'hF;
              endcase
            end
          end
        end else if ((state_q == StHold) && out_ready) begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        if (flush) flushed_d = 1'b1;
        if (mem_ack || timed_out) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'h0;
          state_d = (flushed_q || flush) ? StIdle : StHold;
          if (!mem_ack) begin
            exc_d   = ExcTimeout;
            rd_wr_d = 1'b0;
          end else if (mem_err) begin
            exc_d   = ExcBus;
            rd_wr_d = 1'b0;
          end else if (!we_q) begin
            reg_data_d = ld_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      reg_data_q <= '0;
      rd_addr_q  <= '0;
      rd_wr_q    <= 1'b0;
      exc_q      <= ExcNone;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      off_q      <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_data_q <= reg_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_wr_q    <= rd_wr_d;
      exc_q      <= exc_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
    end
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parameterised memory-access pipeline stage sitting between EXU and WBU. It registers one instruction per slot under valid/ready handshakes on both sides. It runs a variable-latency req/ack memory transaction with byte-lane store alignment and load extension, and returns the write-back payload, which is either the ALU result or the formatted load data. Misaligned accesses, bus errors and timeouts are flagged to the pipeline instead of issuing bad writes.

Parameters:
ADDR_W, 32, memory address width (≥ 2)
REG_AW, 5, register-file address width
TIMEOUT, 15, max cycles waiting for mem_ack before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  kill current slot (branch/exception redirect)
in_valid  in  1  EXU payload valid
in_ready  out  1  stage can accept payload this cycle
in_alu_data  in  32  ALU result (write-back data for non-loads)
in_rd_addr  in  REG_AW  destination register
in_rd_wr  in  1  register write enable
in_mem_rd  in  1  load
in_mem_wr  in  1  store
in_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as misaligned)
in_signed  in  1  sign-extend load
in_mem_addr  in  ADDR_W  effective address
in_store_data  in  32  store data, right-justified
out_valid  out  1  WBU payload valid
out_ready  in  1  WBU accepts
out_reg_data  out  32  write-back data
out_reg_addr  out  REG_AW  destination register
out_reg_wr  out  1  register write enable (forced 0 on exception)
out_exc  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write request
mem_addr  out  ADDR_W  word-aligned address (low two bits 0)
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes
mem_ack  in  1  transaction complete
mem_rdata  in  32  read data, valid with mem_ack
mem_err  in  1  bus error, valid with mem_ack

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk): state IDLE; all payload registers 0; out_valid=0; mem_req=0; mem_we=0; mem_wstrb=0; out_exc=0; in_ready=1.
- States: IDLE, ACCESS, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Capture happens when in_valid & in_ready.
- Capture transitions:
  - Capture of a non-memory op goes to HOLD. out_valid=1 the next cycle (1-cycle latency). out_reg_data=in_alu_data.
  - Capture of a load or store goes to ACCESS, with mem_req=1 from the next cycle.
  - Capture of a misaligned op goes to HOLD with out_exc=1 and out_reg_wr=0; no mem_req. Misaligned means: half with addr[0]=1, word with addr[1:0]≠0, or size=3.
- ACCESS: mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ack. No new capture is allowed (in_ready=0).
  - Write lanes: byte gives wdata={4{d[7:0]}} and wstrb=1<<addr[1:0]. Half gives {2{d[15:0]}} and wstrb=3<<addr[1:0]. Word gives d and wstrb=4'hF.
  - On mem_ack the stage goes to HOLD and mem_req=0 in the same edge. For a load, out_reg_data = selected lane, sign- or zero-extended per in_signed.
  - mem_ack with mem_err=1 sets out_exc=2 and out_reg_wr=0.
  - The wait counter increments each ACCESS cycle without ack. When it reaches TIMEOUT, the stage drops mem_req, sets out_exc=3 and goes to HOLD. A later stray ack is ignored.
  - A load/store with ack on the first req cycle gives 2-cycle capture-to-out_valid latency.
- HOLD: out_valid=1 and the payload is stable while out_ready=0. If out_ready=1 and a new capture occurs, back-to-back throughput is 1/cycle for non-memory ops. If out_ready=1 with no capture, go to IDLE and out_valid=0.
- Stores reach HOLD with out_reg_wr equal to the captured in_rd_wr (normally 0).
- flush:
  - In IDLE/HOLD, flush clears out_valid and blocks capture that cycle. Next state is IDLE.
  - In ACCESS, mem_req stays held until mem_ack; the bus protocol is never abandoned. The result is discarded, out_valid stays 0, then the stage goes to IDLE.
  - Flush during timeout wait ends at the timeout, with no out_valid.
- Simultaneous in_mem_rd & in_mem_wr is treated as a store.
- Async rst mid-ACCESS drops mem_req immediately. The memory side is reset by the same rst.

Test Plan:
- ALU op, alu_data=0x1234_5678, rd=3, out_ready=1 -> out_valid the next cycle with data 0x12345678, rd 3, wr 1, no mem_req; 4 back-to-back ops give 4 consecutive out_valid cycles.
- Byte store d=0x000000AB at addr 0x1003, ack after 3 cycles -> mem_addr 0x1000, wdata 0xABABABAB, wstrb 4'b1000, req held 3 cycles; out_valid one cycle after ack.
- Signed half load at addr 0x2002 with rdata=0x8001_7FFF -> out_reg_data 0xFFFF8001; unsigned gives 0x00008001; signed byte at 0x2001 gives 0x0000007F.
- Word load at addr 0x2001 -> out_exc=1, out_reg_wr=0, no mem_req; ack never asserted with TIMEOUT=4 -> mem_req for exactly 4 cycles, then out_exc=3.
- mem_ack with mem_err=1 on a load to rd=5 -> out_exc=2, out_reg_wr=0.
- out_ready held 0 for 5 cycles in HOLD -> payload stable, in_ready=0.
- Flush asserted during ACCESS -> mem_req held until ack, then IDLE with no out_valid.
- Async rst asserted mid-ACCESS -> mem_req=0 immediately.
